// File: rtl/muldiv_seq_if.sv
// Pipeline-side bundle of the sequential multiply/divide unit: request and operands
// from ID/EX plus the stall, completion and result signals returned to the pipeline.
interface muldiv_seq_if;
  logic        start;
  logic [3:0]  funcCode;
  logic        flush;
  logic [15:0] opA;
  logic [15:0] opB;
  logic        busy;
  logic        stall;
  logic        done;
  logic        regW;
  logic        R15w;
  logic [15:0] resLo;
  logic [15:0] resHi;
  logic        divZero;

  modport master (
    output start, funcCode, flush, opA, opB,
    input  busy, stall, done, regW, R15w, resLo, resHi, divZero
  );

  modport slave (
    input  start, funcCode, flush, opA, opB,
    output busy, stall, done, regW, R15w, resLo, resHi, divZero
  );
endinterface

// File: rtl/muldiv_seq.sv
// 16-bit signed sequential multiplier / restoring divider: one iteration per cycle on
// operand magnitudes, sign fixed up when results are registered on entry to DONE.
module muldiv_seq (
  input  logic         clk,
  input  logic         rst,
  muldiv_seq_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_e;

  localparam logic [3:0] FC_MUL = 4'b0100;
  localparam logic [3:0] FC_DIV = 4'b0101;

  state_e      state_q;
  logic [3:0]  count_q;
  logic [15:0] opa_q;
  logic [15:0] opb_q;
  logic        is_div_q;
  logic [16:0] acc_q;
  logic [15:0] lo_q;
  logic [15:0] res_lo_q;
  logic [15:0] res_hi_q;
  logic        div_zero_q;

  logic        fc_valid_s;
  logic        accept_s;
  logic [15:0] mag_a_s;
  logic [15:0] mag_b_s;
  logic [16:0] acc_d;
  logic [15:0] lo_d;
  logic [16:0] sum_s;
  logic [16:0] shifted_s;
  logic [16:0] diff_s;
  logic [31:0] prod_mag_s;
  logic [31:0] prod_s;
  logic [15:0] quo_s;
  logic [15:0] rem_s;

  function automatic logic [15:0] mag16(input logic [15:0] v);
    mag16 = v[15] ? (16'd0 - v) : v;
  endfunction

  assign fc_valid_s = (bus.funcCode == FC_MUL) || (bus.funcCode == FC_DIV);
  assign accept_s   = (state_q == IDLE) && bus.start && fc_valid_s && !bus.flush;
  assign mag_a_s    = mag16(opa_q);
  assign mag_b_s    = mag16(opb_q);

  // One shift-add or restoring-subtract step, plus the signed results it would yield.
  always_comb begin
    sum_s      = 17'd0;
    shifted_s  = 17'd0;
    diff_s     = 17'd0;
    acc_d      = acc_q;
    lo_d       = lo_q;
    prod_mag_s = 32'd0;
    prod_s     = 32'd0;
    quo_s      = 16'd0;
    rem_s      = 16'd0;
    if (is_div_q) begin
      shifted_s = {acc_q[15:0], lo_q[15]};
      diff_s    = shifted_s - {1'b0, mag_b_s};
      if (shifted_s >= {1'b0, mag_b_s}) begin
        acc_d = diff_s;
        lo_d  = {lo_q[14:0], 1'b1};
      end else begin
        acc_d = shifted_s;
        lo_d  = {lo_q[14:0], 1'b0};
      end
      quo_s = (opa_q[15] ^ opb_q[15]) ? (16'd0 - lo_d) : lo_d;
      rem_s = opa_q[15] ? (16'd0 - acc_d[15:0]) : acc_d[15:0];
    end else begin
      sum_s      = {1'b0, acc_q[15:0]} + (lo_q[0] ? {1'b0, mag_a_s} : 17'd0);
      acc_d      = {1'b0, sum_s[16:1]};
      lo_d       = {sum_s[0], lo_q[15:1]};
      prod_mag_s = {acc_d[15:0], lo_d};
      prod_s     = (opa_q[15] ^ opb_q[15]) ? (32'd0 - prod_mag_s) : prod_mag_s;
    end
  end

  // Control FSM, operand latches, datapath registers and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      count_q    <= 4'd0;
      opa_q      <= 16'd0;
      opb_q      <= 16'd0;
      is_div_q   <= 1'b0;
      acc_q      <= 17'd0;
      lo_q       <= 16'd0;
      res_lo_q   <= 16'd0;
      res_hi_q   <= 16'd0;
      div_zero_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept_s) begin
            opa_q    <= bus.opA;
            opb_q    <= bus.opB;
            is_div_q <= (bus.funcCode == FC_DIV);
            count_q  <= 4'd0;
            acc_q    <= 17'd0;
            lo_q     <= (bus.funcCode == FC_DIV) ? mag16(bus.opA) : mag16(bus.opB);
            // Divide by zero completes immediately with a fixed all-ones quotient.
            if ((bus.funcCode == FC_DIV) && (bus.opB == 16'd0)) begin
              state_q    <= DONE;
              res_lo_q   <= 16'hFFFF;
              res_hi_q   <= bus.opA;
              div_zero_q <= 1'b1;
            end else begin
              state_q <= RUN;
            end
          end else begin
            state_q <= IDLE;
          end
        end
        RUN: begin
          if (bus.flush) begin
            state_q <= IDLE;
          end else begin
            acc_q <= acc_d;
            lo_q  <= lo_d;
            if (count_q == 4'd15) begin
              state_q    <= DONE;
              res_lo_q   <= is_div_q ? quo_s : prod_s[15:0];
              res_hi_q   <= is_div_q ? rem_s : prod_s[31:16];
              div_zero_q <= 1'b0;
            end else begin
              count_q <= count_q + 4'd1;
            end
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy    = (state_q != IDLE);
  // A flushed instruction must not write back even if it already reached DONE.
  assign bus.done    = (state_q == DONE) && !bus.flush;
  assign bus.regW    = bus.done;
  assign bus.R15w    = bus.done;
  assign bus.stall   = !rst && (accept_s || (state_q == RUN));
  assign bus.resLo   = res_lo_q;
  assign bus.resHi   = res_hi_q;
  assign bus.divZero = div_zero_q;

endmodule
